// File: rtl/decode_stage.sv
// Decode stage: unpacks the fetch->decode latch, decodes RV32I register fields and
// tracks in-flight destinations in a busy-bit scoreboard to stall fetch on RAW/WAW hazards.
module decode_stage #(
  parameter int DBITS      = 32,
  parameter int INSTBITS   = 32,
  parameter int REGNO      = 32,
  parameter int REGBITS    = 5,
  parameter int CANARYBITS = 16,
  parameter logic [CANARYBITS-1:0] CANARY = 16'hCAFE,
  parameter int FE_W       = INSTBITS + 3*DBITS + CANARYBITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FE_W-1:0]       fe_latch_in,
  input  logic                  flush_in,
  input  logic                  wb_we,
  input  logic [REGBITS-1:0]    wb_rd,
  output logic                  stall_to_fe,
  output logic                  de_valid_out,
  output logic [INSTBITS-1:0]   de_inst_out,
  output logic [DBITS-1:0]      de_pc_out,
  output logic [DBITS-1:0]      de_pcplus_out,
  output logic [DBITS-1:0]      de_icnt_out,
  output logic [REGBITS-1:0]    de_rs1_out,
  output logic [REGBITS-1:0]    de_rs2_out,
  output logic [REGBITS-1:0]    de_rd_out,
  output logic                  de_illegal_out,
  output logic [REGNO-1:0]      busy_out,
  output logic                  canary_err
);

  logic [INSTBITS-1:0]   w_inst;
  logic [DBITS-1:0]      w_pc;
  logic [DBITS-1:0]      w_pcplus;
  logic [DBITS-1:0]      w_icnt;
  logic [CANARYBITS-1:0] w_canary;

  assign w_inst   = fe_latch_in[FE_W-1 -: INSTBITS];
  assign w_pc     = fe_latch_in[3*DBITS+CANARYBITS-1 -: DBITS];
  assign w_pcplus = fe_latch_in[2*DBITS+CANARYBITS-1 -: DBITS];
  assign w_icnt   = fe_latch_in[DBITS+CANARYBITS-1 -: DBITS];
  assign w_canary = fe_latch_in[CANARYBITS-1:0];

  logic w_fe_valid;
  logic w_use_rs1, w_use_rs2, w_use_rd, w_illegal;

  // An all-zero instruction is the bubble fetch emits on reset/redirect.
  assign w_fe_valid = (w_inst != '0);

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_illegal = 1'b0;
    case (w_inst[6:0])
      7'b0110011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_use_rd  = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_use_rs1 = 1'b1;
        w_use_rd  = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      7'b1101111, 7'b0110111, 7'b0010111: w_use_rd = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end

  logic [REGBITS-1:0] w_rs1, w_rs2, w_rd;
  assign w_rs1 = w_use_rs1 ? w_inst[15 +: REGBITS] : '0;
  assign w_rs2 = w_use_rs2 ? w_inst[20 +: REGBITS] : '0;
  assign w_rd  = w_use_rd  ? w_inst[7  +: REGBITS] : '0;

  logic [REGNO-1:0] r_busy;
  logic [REGNO-1:0] w_wb_mask, w_set_mask, w_busy_eff;
  logic             w_hazard, w_issue;

  // Writeback in the same cycle is visible to decode (write-first register file).
  assign w_wb_mask  = (wb_we && wb_rd != '0) ? (REGNO'(1) << wb_rd) : '0;
  assign w_busy_eff = r_busy & ~w_wb_mask;

  assign w_hazard = w_fe_valid & ((w_use_rs1 & w_busy_eff[w_rs1]) |
                                  (w_use_rs2 & w_busy_eff[w_rs2]) |
                                  (w_use_rd  & w_busy_eff[w_rd]));
  assign w_issue    = w_fe_valid & ~w_hazard & ~flush_in;
  assign w_set_mask = (w_issue && w_rd != '0) ? (REGNO'(1) << w_rd) : '0;
  assign stall_to_fe = w_hazard & ~flush_in;

  logic                r_valid, r_illegal, r_canary_err;
  logic [INSTBITS-1:0] r_inst;
  logic [DBITS-1:0]    r_pc, r_pcplus, r_icnt;
  logic [REGBITS-1:0]  r_rs1, r_rs2, r_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy       <= '0;
      r_canary_err <= 1'b0;
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
      r_inst       <= '0;
      r_pc         <= '0;
      r_pcplus     <= '0;
      r_icnt       <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
    end else begin
      // Set after clear so an issue wins over a same-cycle writeback of that register.
      r_busy <= (r_busy & ~w_wb_mask) | w_set_mask;
      if (w_fe_valid && w_canary != CANARY) r_canary_err <= 1'b1;
      r_valid   <= w_issue;
      r_illegal <= w_issue & w_illegal;
      r_inst    <= w_issue ? w_inst   : '0;
      r_pc      <= w_issue ? w_pc     : '0;
      r_pcplus  <= w_issue ? w_pcplus : '0;
      r_icnt    <= w_issue ? w_icnt   : '0;
      r_rs1     <= w_issue ? w_rs1    : '0;
      r_rs2     <= w_issue ? w_rs2    : '0;
      r_rd      <= w_issue ? w_rd     : '0;
    end
  end

  assign de_valid_out   = r_valid;
  assign de_inst_out    = r_inst;
  assign de_pc_out      = r_pc;
  assign de_pcplus_out  = r_pcplus;
  assign de_icnt_out    = r_icnt;
  assign de_rs1_out     = r_rs1;
  assign de_rs2_out     = r_rs2;
  assign de_rd_out      = r_rd;
  assign de_illegal_out = r_illegal;
  assign busy_out       = r_busy;
  assign canary_err     = r_canary_err;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, an async reset mid-stall, then
// randomized traffic checked against a set-based scoreboard model.
module tb_decode_stage;
  localparam logic [15:0] CF = 16'hCAFE;

  logic         clk = 1'b0;
  logic         reset;
  logic [143:0] fe_latch_in;
  logic         flush_in, wb_we;
  logic [4:0]   wb_rd;
  logic         stall_to_fe, de_valid_out, de_illegal_out, canary_err;
  logic [31:0]  de_inst_out, de_pc_out, de_pcplus_out, de_icnt_out, busy_out;
  logic [4:0]   de_rs1_out, de_rs2_out, de_rd_out;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .fe_latch_in(fe_latch_in), .flush_in(flush_in),
    .wb_we(wb_we), .wb_rd(wb_rd), .stall_to_fe(stall_to_fe),
    .de_valid_out(de_valid_out), .de_inst_out(de_inst_out), .de_pc_out(de_pc_out),
    .de_pcplus_out(de_pcplus_out), .de_icnt_out(de_icnt_out), .de_rs1_out(de_rs1_out),
    .de_rs2_out(de_rs2_out), .de_rd_out(de_rd_out), .de_illegal_out(de_illegal_out),
    .busy_out(busy_out), .canary_err(canary_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] icnt,
                       input logic [15:0] can, input logic fl, input logic we, input logic [4:0] wrd);
    fe_latch_in = (inst == 32'd0) ? '0 : {inst, pc, pc + 32'd4, icnt, can};
    flush_in = fl;
    wb_we    = we;
    wb_rd    = wrd;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [15:0] can;
    logic        fl;
    logic        we;
    logic [4:0]  wrd;
    logic        stall;
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        ill;
    logic [31:0] busy;
    logic        cerr;
  } vec_t;

  vec_t tbl[14];

  // Reference decode: which register fields each opcode reads/writes.
  function automatic void ref_fields(input logic [31:0] inst, output bit u1, output bit u2,
                                     output bit ud, output bit ill);
    logic [6:0] op;
    op  = inst[6:0];
    u1  = op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63};
    u2  = op inside {7'h33, 7'h23, 7'h63};
    ud  = op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h6F, 7'h37, 7'h17};
    ill = !(u1 || ud);
  endfunction

  bit          m_busy[32];
  bit          m_cerr;
  logic [31:0] m_inst, m_pc, m_icnt;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  bit          m_valid, m_ill;

  initial begin
    logic [31:0] pc, inst, busy_vec;
    logic [15:0] can;
    logic [4:0]  r1, r2, rdd, wrd;
    logic        fl, we;
    bit u1, u2, ud, ill, fev, haz, issue;
    logic [6:0]  ops[11];

    reset = 1'b1;
    drive(32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 5'd0);
    #2;
    chk("reset_valid", de_valid_out, 1'b0);
    chk("reset_busy", busy_out, 32'd0);
    chk("reset_stall", stall_to_fe, 1'b0);
    chk("reset_cerr", canary_err, 1'b0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    //            inst          can     fl    we    wrd   stall valid rs1   rs2   rd    ill   busy          cerr
    tbl[0]  = '{32'h002081B3, CF,     1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0000_0008, 1'b0};
    tbl[1]  = '{32'h00118213, CF,     1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0008, 1'b0};
    tbl[2]  = '{32'h00118213, CF,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0008, 1'b0};
    tbl[3]  = '{32'h00118213, CF,     1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd3, 5'd0, 5'd4, 1'b0, 32'h0000_0010, 1'b0};
    tbl[4]  = '{32'h00000013, CF,     1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0010, 1'b0};
    tbl[5]  = '{32'h002081B3, CF,     1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0000_0018, 1'b0};
    tbl[6]  = '{32'h002081B3, CF,     1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0008, 1'b0};
    tbl[7]  = '{32'h00000000, CF,     1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0000, 1'b0};
    tbl[8]  = '{32'h00000013, 16'h0,  1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0000, 1'b1};
    tbl[9]  = '{32'h00000000, 16'h0,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0000, 1'b1};
    tbl[10] = '{32'hFFFFFFFF, CF,     1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_0000, 1'b1};
    tbl[11] = '{32'h0000A0B7, CF,     1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 32'h0000_0002, 1'b1};
    tbl[12] = '{32'h00102023, CF,     1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0002, 1'b1};
    tbl[13] = '{32'h00102023, CF,     1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 5'd0, 5'd1, 5'd0, 1'b0, 32'h0000_0000, 1'b1};

    for (int i = 0; i < 14; i++) begin
      pc = 32'h200 + 32'(4 * i);
      drive(tbl[i].inst, pc, 32'(i), tbl[i].can, tbl[i].fl, tbl[i].we, tbl[i].wrd);
      #3;
      chk($sformatf("v%0d_stall", i), stall_to_fe, tbl[i].stall);
      @(posedge clk); #1;
      $display("vec %0d: inst=%08h stall=%0b valid=%0b rd=%0d busy=%08h cerr=%0b",
               i, tbl[i].inst, tbl[i].stall, de_valid_out, de_rd_out, busy_out, canary_err);
      chk($sformatf("v%0d_valid", i), de_valid_out, tbl[i].valid);
      chk($sformatf("v%0d_regs", i), {de_rs1_out, de_rs2_out, de_rd_out},
          {tbl[i].rs1, tbl[i].rs2, tbl[i].rd});
      chk($sformatf("v%0d_ill", i), de_illegal_out, tbl[i].ill);
      chk($sformatf("v%0d_inst", i), de_inst_out, tbl[i].valid ? tbl[i].inst : 32'd0);
      chk($sformatf("v%0d_pc", i), {de_pc_out, de_pcplus_out},
          tbl[i].valid ? {pc, pc + 32'd4} : 64'd0);
      chk($sformatf("v%0d_busy", i), busy_out, tbl[i].busy);
      chk($sformatf("v%0d_cerr", i), canary_err, tbl[i].cerr);
    end

    // Async reset while fetch is stalled on a RAW hazard.
    drive(32'h002081B3, 32'h300, 32'd0, CF, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    drive(32'h00118213, 32'h304, 32'd1, CF, 1'b0, 1'b0, 5'd0);
    #2;
    chk("rst_pre_stall", stall_to_fe, 1'b1);
    reset = 1'b1;
    #1;
    $display("async reset: stall=%0b busy=%08h valid=%0b cerr=%0b",
             stall_to_fe, busy_out, de_valid_out, canary_err);
    chk("rst_stall", stall_to_fe, 1'b0);
    chk("rst_busy", busy_out, 32'd0);
    chk("rst_valid", de_valid_out, 1'b0);
    chk("rst_cerr", canary_err, 1'b0);
    chk("rst_fields", {de_inst_out, de_rd_out}, 37'd0);
    drive(32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic against the model.
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F, 7'h0B};
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    m_cerr = 1'b0;
    for (int n = 0; n < 400; n++) begin
      inst = $urandom;
      inst[6:0]   = ops[$urandom_range(0, 10)];
      inst[11:7]  = 5'($urandom_range(0, 7));
      inst[19:15] = 5'($urandom_range(0, 7));
      inst[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) inst = 32'd0;
      pc  = {$urandom_range(0, 32'h3FFF), 2'b00};
      can = ($urandom_range(0, 39) == 0) ? 16'($urandom) : CF;
      fl  = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 2) == 0);
      wrd = 5'($urandom_range(0, 7));
      drive(inst, pc, 32'(n), can, fl, we, wrd);

      fev = (inst != 32'd0);
      ref_fields(inst, u1, u2, ud, ill);
      r1  = u1 ? inst[19:15] : 5'd0;
      r2  = u2 ? inst[24:20] : 5'd0;
      rdd = ud ? inst[11:7]  : 5'd0;
      haz = fev && ((u1 && m_busy[r1] && !(we && wrd == r1)) ||
                    (u2 && m_busy[r2] && !(we && wrd == r2)) ||
                    (ud && m_busy[rdd] && !(we && wrd == rdd)));
      issue = fev && !haz && !fl;
      #3;
      chk("rnd_stall", stall_to_fe, haz && !fl);
      @(posedge clk);

      if (we && wrd != 5'd0) m_busy[wrd] = 1'b0;
      if (issue && rdd != 5'd0) m_busy[rdd] = 1'b1;
      if (fev && can != CF) m_cerr = 1'b1;
      m_valid = issue;
      m_inst  = issue ? inst : 32'd0;
      m_pc    = issue ? pc : 32'd0;
      m_icnt  = issue ? 32'(n) : 32'd0;
      m_rs1   = issue ? r1 : 5'd0;
      m_rs2   = issue ? r2 : 5'd0;
      m_rd    = issue ? rdd : 5'd0;
      m_ill   = issue && ill;
      for (int r = 0; r < 32; r++) busy_vec[r] = m_busy[r];

      #1;
      $display("rnd %0d: inst=%08h fl=%0b wb=%0b/%0d valid=%0b busy=%08h",
               n, inst, fl, we, wrd, de_valid_out, busy_out);
      chk("rnd_valid", de_valid_out, m_valid);
      chk("rnd_inst", de_inst_out, m_inst);
      chk("rnd_pc", {de_pc_out, de_pcplus_out}, issue ? {m_pc, m_pc + 32'd4} : 64'd0);
      chk("rnd_icnt", de_icnt_out, m_icnt);
      chk("rnd_regs", {de_rs1_out, de_rs2_out, de_rd_out}, {m_rs1, m_rs2, m_rd});
      chk("rnd_ill", de_illegal_out, m_ill);
      chk("rnd_busy", busy_out, busy_vec);
      chk("rnd_cerr", canary_err, m_cerr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
